// File: rtl/online_arith_pkg.sv
// Shared definitions for the on-line arithmetic blocks: signed-digit rail
// encodings, the converter state type and the digit decode helper.
package online_arith_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  // Both rails high cancel each other and are read as a zero digit.
  localparam logic [1:0] SD_BOTH = 2'b11;

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_DONE   = 1'b1
  } state_t;

  function automatic logic signed [1:0] sd_decode(input logic plus, input logic minus);
    case ({plus, minus})
      SD_POS:  return 2'sb01;
      SD_NEG:  return 2'sb11;
      SD_ZERO: return 2'sb00;
      SD_BOTH: return 2'sb00;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/online_sd_to_binary_otf_update.sv
// On-the-fly conversion step: appends one signed digit to the Q/QM pair,
// keeping QM = Q - 1 so no carry ever has to ripple.
module otf_update #(
  parameter int W = 9
) (
  input  logic        [W-1:0] q,
  input  logic        [W-1:0] qm,
  input  logic signed [1:0]   digit,
  output logic        [W-1:0] q_next,
  output logic        [W-1:0] qm_next
);

  // The MSB shifted out is dropped; the final value always fits in W bits.
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (digit)
      2'b01: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      2'b11: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/online_sd_to_binary.sv
// Serial MSD-first signed-digit to two's complement converter with
// valid/ready handshakes on both the digit input and the result output.
module online_sd_to_binary
  import online_arith_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              d_plus,
  input  logic              d_minus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIGITS:0]   result
);

  localparam int W  = DIGITS + 1;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [W-1:0]       q;
  logic [W-1:0]       qm;
  logic [W-1:0]       q_next;
  logic [W-1:0]       qm_next;
  logic signed [1:0]  digit;
  logic               accept;

  assign in_ready  = (state == ST_ACCEPT);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign digit     = sd_decode(d_plus, d_minus);
  assign result    = q;

  otf_update #(
    .W(W)
  ) u_otf (
    .q       (q),
    .qm      (qm),
    .digit   (digit),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  // Returning to ACCEPT reloads Q/QM, so the next operand starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACCEPT;
      cnt   <= '0;
      q     <= '0;
      qm    <= '1;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (accept) begin
            q  <= q_next;
            qm <= qm_next;
            if (cnt == LAST) begin
              state <= ST_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_ACCEPT;
            q     <= '0;
            qm    <= '1;
          end
        end
        default: begin
          state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_online_sd_to_binary.sv
// Bench for the signed-digit converter: directed operands plus random
// streams checked against an integer accumulation model.
module tb_online_sd_to_binary;

  localparam int DIGITS = 4;
  localparam int W      = DIGITS + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         d_plus;
  logic         d_minus;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  online_sd_to_binary #(
    .DIGITS(DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit value of a rail pair from the encoding table.
  function automatic int digit_value(input logic [1:0] rails);
    if (rails == 2'b10) return 1;
    if (rails == 2'b01) return -1;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one digit and waits (bounded) for it to be taken.
  task automatic send_beat(input logic [1:0] rails, input string name);
    int t;
    t = 0;
    in_valid = 1'b1;
    {d_plus, d_minus} = rails;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s in_ready timeout: got %b want 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    {d_plus, d_minus} = 2'b00;
  endtask

  // Runs one full operand: gaps before beats, partial-result checks, backpressure
  // hold while a stray digit is offered, then the output handshake.
  task automatic run_operand(input logic [2*DIGITS-1:0] rails, input int max_gap,
                             input int hold, input bit use_want,
                             input logic [W-1:0] want, input string name);
    int acc;
    int gap;
    logic [1:0] r;
    logic [W-1:0] exp_val;
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
        step();
        exp_val = W'(acc);
        checks++;
        if (result !== exp_val || in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s gap: result %h in_ready %b want %h 1", name, result, in_ready, exp_val);
        end
      end
      r = rails[2*DIGITS-1-2*i -: 2];
      send_beat(r, name);
      acc = acc * 2 + digit_value(r);
      exp_val = W'(acc);
      if (i < DIGITS - 1) begin
        checks++;
        if (result !== exp_val || out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s partial%0d: result %h out_valid %b want %h 0", name, i, result, out_valid, exp_val);
        end
      end
    end
    exp_val = W'(acc);
    if (use_want) begin
      checks++;
      if (want !== exp_val) begin
        errors++;
        $display("[TB] FAIL %s model: got %h want %h", name, exp_val, want);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_val) begin
      errors++;
      $display("[TB] FAIL %s done: out_valid %b in_ready %b result %h want 1 0 %h", name, out_valid, in_ready, result, exp_val);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      {d_plus, d_minus} = 2'($urandom_range(3, 0));
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_val) begin
        errors++;
        $display("[TB] FAIL %s hold%0d: out_valid %b in_ready %b result %h want 1 0 %h", name, h, out_valid, in_ready, result, exp_val);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("[TB] FAIL %s release: out_valid %b in_ready %b result %h want 0 1 0", name, out_valid, in_ready, result);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {d_plus, d_minus} = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("[TB] FAIL reset: out_valid %b in_ready %b result %h want 0 1 0", out_valid, in_ready, result);
    end
  endtask

  task automatic test_directed();
    run_operand(8'b10_00_01_10, 0, 0, 1'b1, 5'b00111, "mixed");
    run_operand(8'b01_01_01_01, 0, 0, 1'b1, 5'b10001, "neg15");
    run_operand(8'b10_10_10_10, 0, 0, 1'b1, 5'b01111, "pos15");
    run_operand(8'b00_11_00_01, 0, 0, 1'b1, 5'b11111, "neg1");
    run_operand(8'b00_00_00_00, 0, 0, 1'b1, 5'b00000, "zero");
  endtask

  task automatic test_backpressure();
    run_operand(8'b10_00_01_10, 0, 3, 1'b1, 5'b00111, "backpressure");
  endtask

  task automatic test_gaps();
    run_operand(8'b10_00_01_10, 0, 0, 1'b1, 5'b00111, "nogap");
    for (int k = 0; k < 3; k++) begin
      // Gap lengths are random, up to 2 idle cycles before each beat.
      run_operand(8'b10_00_01_10, 2, 0, 1'b1, 5'b00111, "gaps");
    end
  endtask

  task automatic test_reset_mid();
    send_beat(2'b10, "midreset");
    send_beat(2'b01, "midreset");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("[TB] FAIL midreset: out_valid %b in_ready %b result %h want 0 1 0", out_valid, in_ready, result);
    end
    run_operand(8'b00_00_10_00, 0, 0, 1'b1, 5'b00010, "after_reset");
  endtask

  task automatic test_random();
    logic [2*DIGITS-1:0] rails;
    for (int n = 0; n < 40; n++) begin
      rails = (2*DIGITS)'($urandom);
      run_operand(rails, 3, $urandom_range(3, 0), 1'b0, '0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
